multdiv_seq_ctrl: RTL and testbench

//   Sequences the multi-cycle mult/div unit for the single-cycle processor.
//   - Detects R-type mul/div in decode and issues a one-cycle ctrl_MULT/ctrl_DIV start pulse.
//   - Holds the PC/fetch stalled until data_resultRDY, or until a timeout expires.
//   - Produces a one-cycle register-file write: result to rd, or an exception code to rstatus.
//   - Sits between the control decoder, the multdiv unit and the regfile write-port mux.

---
 rtl/multdiv_seq_ctrl_pkg.sv | 39 +++
 rtl/multdiv_seq_ctrl_if.sv | 32 +++
 rtl/multdiv_seq_ctrl_timeout.sv | 37 +++
 rtl/multdiv_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_multdiv_seq_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/multdiv_seq_ctrl_pkg.sv
// Shared types and constants for the mult/div sequencing controller.
package multdiv_seq_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned PERF_W = 32;

  localparam logic [OP_W-1:0] ALU_OP_MUL = 5'b00110;
  localparam logic [OP_W-1:0] ALU_OP_DIV = 5'b00111;

  localparam int unsigned        TIMEOUT_CYCLES_DEF = 40;
  localparam logic [REG_W-1:0]   RSTATUS_REG_DEF    = 5'd30;
  localparam logic [DATA_W-1:0]  MUL_EXC_CODE_DEF   = 32'd4;
  localparam logic [DATA_W-1:0]  DIV_EXC_CODE_DEF   = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

  // Register-file write request presented during the WB cycle.
  typedef struct packed {
    logic              en;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic is_md_op(input logic is_r, input logic [OP_W-1:0] op);
    return is_r & ((op == ALU_OP_MUL) | (op == ALU_OP_DIV));
  endfunction

endpackage

// File: rtl/multdiv_seq_ctrl_if.sv
// Decode / multdiv / regfile-write signals seen by the mult/div sequencer.
interface multdiv_seq_ctrl_if;
  import multdiv_seq_ctrl_pkg::*;

  logic              is_R;
  logic [OP_W-1:0]   alu_op;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_ready;

  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic              stall;
  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [PERF_W-1:0] perf_busy_cycles;

  // Environment side: decoder and multdiv unit drive, pipeline consumes.
  modport master (
    output is_R, alu_op, rd, md_result, md_exception, md_ready,
    input  ctrl_MULT, ctrl_DIV, stall, wb_en, wb_reg, wb_data, perf_busy_cycles
  );

  // Controller side.
  modport slave (
    input  is_R, alu_op, rd, md_result, md_exception, md_ready,
    output ctrl_MULT, ctrl_DIV, stall, wb_en, wb_reg, wb_data, perf_busy_cycles
  );

endinterface

// File: rtl/multdiv_seq_ctrl_timeout.sv
// Busy-cycle counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module md_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic term_cnt_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at TIMEOUT_CYCLES so a stray enable can never wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_cnt_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequences the multi-cycle mult/div unit: start pulse, stall, timeout, one-cycle writeback.
// Optional MD_PERF_CNT_EN adds a saturating stall-cycle counter on perf_busy_cycles.
module multdiv_seq_ctrl
  import multdiv_seq_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [REG_W-1:0]  RSTATUS_REG    = RSTATUS_REG_DEF,
  parameter logic [DATA_W-1:0] MUL_EXC_CODE   = MUL_EXC_CODE_DEF,
  parameter logic [DATA_W-1:0] DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
  input  logic               clock,
  input  logic               reset,
  multdiv_seq_ctrl_if.slave  md_bus
);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [REG_W-1:0] rd_q, rd_d;
  wb_req_t          wb_q, wb_d;

  logic issue_c;
  logic stall_c;
  logic start_mul_c;
  logic start_div_c;
  logic cnt_clear_c;
  logic cnt_en_c;
  logic timeout_c;
  logic exc_c;

  // Issue is gated by reset so start pulses vanish the moment reset asserts.
  assign issue_c = reset & is_md_op(md_bus.is_R, md_bus.alu_op);

  md_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clock),
    .rst_n      (reset),
    .clear_i    (cnt_clear_c),
    .enable_i   (cnt_en_c),
    .term_cnt_c (timeout_c)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    wb_d        = '0;
    stall_c     = 1'b0;
    start_mul_c = 1'b0;
    start_div_c = 1'b0;
    cnt_clear_c = 1'b0;
    cnt_en_c    = 1'b0;
    exc_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (issue_c) begin
          stall_c     = 1'b1;
          start_mul_c = (md_bus.alu_op == ALU_OP_MUL);
          start_div_c = (md_bus.alu_op == ALU_OP_DIV);
          op_d        = (md_bus.alu_op == ALU_OP_DIV) ? OP_DIV : OP_MUL;
          rd_d        = md_bus.rd;
          cnt_clear_c = 1'b1;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        stall_c  = 1'b1;
        cnt_en_c = 1'b1;
        // A ready arriving on the timeout cycle still delivers its own result.
        if (md_bus.md_ready || timeout_c) begin
          exc_c   = md_bus.md_ready ? md_bus.md_exception : 1'b1;
          state_d = ST_WB;
          if (exc_c) begin
            wb_d.en   = 1'b1;
            wb_d.addr = RSTATUS_REG;
            wb_d.data = (op_q == OP_MUL) ? MUL_EXC_CODE : DIV_EXC_CODE;
          end else begin
            wb_d.en   = (rd_q != '0);
            wb_d.addr = rd_q;
            wb_d.data = md_bus.md_result;
          end
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
    end
  end

  assign md_bus.ctrl_MULT = start_mul_c;
  assign md_bus.ctrl_DIV  = start_div_c;
  assign md_bus.stall     = stall_c;
  assign md_bus.wb_en     = wb_q.en;
  assign md_bus.wb_reg    = wb_q.addr;
  assign md_bus.wb_data   = wb_q.data;

`ifdef MD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (stall_c && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign md_bus.perf_busy_cycles = perf_q;
`else
  assign md_bus.perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Randomized self-checking bench for multdiv_seq_ctrl against a transaction-level model.
module tb_multdiv_seq_ctrl;
  import multdiv_seq_ctrl_pkg::*;

  localparam int unsigned TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multdiv_seq_ctrl_if bus();

  multdiv_seq_ctrl dut (
    .clock  (clk),
    .reset  (rst_n),
    .md_bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] perf_exp = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef MD_PERF_CNT_EN
    check_eq(tag, bus.perf_busy_cycles, perf_exp);
`else
    check_eq(tag, bus.perf_busy_cycles, 32'd0);
`endif
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".stall"},  32'(bus.stall), 32'd0);
    check_eq({tag, ".pulse"},  32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
    check_eq({tag, ".wb_en"},  32'(bus.wb_en), 32'd0);
    check_eq({tag, ".wb_reg"}, 32'(bus.wb_reg), 32'd0);
    check_eq({tag, ".wb_data"}, bus.wb_data, 32'd0);
  endtask

  // One cycle with a non mul/div instruction in decode (is_R may be either value).
  task automatic idle_cycle(input bit force_add);
    logic [4:0] op;
    @(negedge clk);
    op = 5'($urandom_range(0, 31));
    if (force_add || op == 5'b00110 || op == 5'b00111) op = 5'b00000;
    bus.is_R         = force_add ? 1'b1 : 1'($urandom);
    bus.alu_op       = op;
    bus.rd           = 5'($urandom);
    bus.md_ready     = 1'($urandom);
    bus.md_exception = 1'($urandom);
    bus.md_result    = $urandom;
    #1;
    check_quiet(force_add ? "add" : "idle");
    check_perf("idle.perf");
  endtask

  // k = cycle after issue at which md_ready pulses; 0 or > TIMEOUT means never.
  task automatic run_op(input bit is_div, input logic [4:0] rd, input int unsigned k, input bit exc);
    int unsigned m;
    bit          ready_seen;
    bit          exc_exp;
    logic [31:0] res_exp;
    ready_seen = (k >= 1) && (k <= TIMEOUT);
    m          = ready_seen ? k : TIMEOUT;
    res_exp    = '0;

    @(negedge clk);
    bus.is_R     = 1'b1;
    bus.alu_op   = is_div ? 5'b00111 : 5'b00110;
    bus.rd       = rd;
    bus.md_ready = 1'b0;
    #1;
    check_eq("issue.mult",  32'(bus.ctrl_MULT), 32'(!is_div));
    check_eq("issue.div",   32'(bus.ctrl_DIV), 32'(is_div));
    check_eq("issue.stall", 32'(bus.stall), 32'd1);
    check_eq("issue.wb_en", 32'(bus.wb_en), 32'd0);

    for (int c = 1; c <= int'(m); c++) begin
      @(negedge clk);
      bus.md_ready     = (c == int'(k));
      bus.md_result    = $urandom;
      bus.md_exception = (c == int'(k)) ? exc : 1'($urandom);
      if (c == int'(k)) res_exp = bus.md_result;
      #1;
      check_eq("busy.stall", 32'(bus.stall), 32'd1);
      check_eq("busy.pulse", 32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
      check_eq("busy.wb_en", 32'(bus.wb_en), 32'd0);
    end
    perf_exp = perf_exp + 32'(1 + m);

    exc_exp = ready_seen ? exc : 1'b1;
    @(negedge clk);
    bus.md_ready  = 1'b0;
    bus.md_result = $urandom;
    #1;
    check_eq("wb.stall", 32'(bus.stall), 32'd0);
    check_eq("wb.pulse", 32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
    if (exc_exp) begin
      check_eq("wb.exc_en",   32'(bus.wb_en), 32'd1);
      check_eq("wb.exc_reg",  32'(bus.wb_reg), 32'd30);
      check_eq("wb.exc_data", bus.wb_data, is_div ? 32'd5 : 32'd4);
    end else begin
      check_eq("wb.en",   32'(bus.wb_en), 32'(rd != 5'd0));
      check_eq("wb.reg",  32'(bus.wb_reg), 32'(rd));
      check_eq("wb.data", bus.wb_data, res_exp);
    end
    check_perf("wb.perf");
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.is_R         = 1'b0;
    bus.alu_op       = '0;
    bus.rd           = '0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_ready     = 1'b0;
    #1;
    check_quiet("reset");
    check_eq("reset.perf", bus.perf_busy_cycles, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle_cycle(1'b0);
    run_op(1'b0, 5'd3, 16, 1'b0);
    run_op(1'b1, 5'd7, $urandom_range(1, 30), 1'b1);
    run_op(1'b0, 5'd0, 5, 1'b0);
    idle_cycle(1'b1);
    run_op(1'b1, 5'd12, 0, 1'b0);
    run_op(1'b0, 5'd4, 0, 1'b0);
    run_op(1'b1, 5'd5, TIMEOUT, 1'b0);
    run_op(1'b0, 5'd6, TIMEOUT - 1, 1'b0);
    idle_cycle(1'b1);
    run_op(1'b0, 5'd9, 3, 1'b0);
    run_op(1'b1, 5'd10, 1, 1'b0);
    idle_cycle(1'b0);

    // Reset in the fifth BUSY cycle abandons the op with no writeback.
    @(negedge clk);
    bus.is_R     = 1'b1;
    bus.alu_op   = 5'b00111;
    bus.rd       = 5'd9;
    bus.md_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    perf_exp = '0;
    check_quiet("midreset");
    check_perf("midreset.perf");
    @(negedge clk);
    #1;
    check_quiet("midreset.hold");
    @(negedge clk);
    rst_n    = 1'b1;
    bus.is_R = 1'b0;
    repeat (4) idle_cycle(1'b0);
    run_op(1'b1, 5'd11, 8, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) idle_cycle(1'b0);
      run_op(1'($urandom), 5'($urandom), $urandom_range(0, 45), 1'($urandom));
    end
    idle_cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
